// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests,
// response buffer toward decode, redirect flush with stale drop.
module if_fetch #(
    parameter int unsigned          IR_WIDTH   = 32,
    parameter logic [IR_WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [IR_WIDTH-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [IR_WIDTH-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [IR_WIDTH-1:0] redirect_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [IR_WIDTH-1:0] ir,
    output logic [IR_WIDTH-1:0] ir_pc
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [IR_WIDTH-1:0] STEP = IR_WIDTH'(4);

    typedef struct packed {
        logic [IR_WIDTH-1:0] data;
        logic [IR_WIDTH-1:0] pc;
    } ent_t;

    logic [IR_WIDTH-1:0] pc;
    logic [IR_WIDTH-1:0] rsp_pc;
    logic [IR_WIDTH-1:0] target;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       outstanding_nxt;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       count;
    logic [CW:0]         inflight;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    ent_t                mem [FIFO_DEPTH];
    logic                req_fire;
    logic                push;
    logic                pop;

    // Credits cover both in-flight words and buffered words, so a
    // response always finds room in the buffer.
    assign inflight = {1'b0, outstanding} + {1'b0, count};

    assign imem_req_valid = rst_n && !redirect_valid
                         && (inflight < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign ir_valid = (count != '0);
    assign ir       = mem[rd_ptr].data;
    assign ir_pc    = mem[rd_ptr].pc;

    assign push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign pop  = ir_valid && ir_ready && !redirect_valid;

    assign outstanding_nxt = outstanding + CW'(req_fire)
                           - CW'(imem_rsp_valid);
    assign target = redirect_pc & ~IR_WIDTH'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                pc       <= target;
                rsp_pc   <= target;
                drop_cnt <= outstanding_nxt;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    pc <= pc + STEP;
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    mem[wr_ptr] <= '{data: imem_rsp_data, pc: rsp_pc};
                    wr_ptr      <= wr_ptr + 1'b1;
                    rsp_pc      <= rsp_pc + STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    a_rsp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding == '0)));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt <= outstanding);
    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory model with latency, stream scoreboard,
// redirect scenario table and hand-built corner sequences.
module tb_if_fetch;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    always #5 clk = ~clk;

    if_fetch #(
        .IR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir(ir), .ir_pc(ir_pc)
    );

    typedef struct { logic [31:0] addr; int cyc; bit stale; } mreq_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
    typedef struct {
        int lat; int pre; int post; bit rr; bit mr;
        logic [31:0] rd_pc; logic [31:0] exp1; logic [31:0] exp2;
    } row_t;

    mreq_t       memq[$];
    ent_t        sbq[$];
    logic [31:0] reqs[$];
    logic [31:0] popped[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 1;
    bit rdy = 1'b1;
    bit mem_rdy = 1'b1;
    bit do_redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] exp_pc = '0;
    bit last_rv, last_popc, last_irv;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] q[$],
                         input int idx, input logic [31:0] exp);
        if (idx < q.size()) begin
            chk(name, q[idx], exp);
        end else begin
            tests++;
            fails++;
            $display("FAIL %s: got no entry %0d expected %h", name, idx, exp);
        end
    endtask

    task automatic step();
        bit   rv, hs, popc;
        mreq_t h;
        ent_t  e;
        @(negedge clk);
        cyc++;
        rv = (memq.size() > 0) && (memq[0].cyc + lat <= cyc);
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mdata(memq[0].addr) : '0;
        redirect_valid = do_redir;
        redirect_pc    = redir_pc;
        ir_ready       = rdy;
        imem_req_ready = mem_rdy;
        #1;
        chk("req_valid", 32'(imem_req_valid),
            32'(!do_redir && (memq.size() + sbq.size() < D)));
        chk("ir_valid", 32'(ir_valid), 32'(sbq.size() != 0));
        hs   = imem_req_valid && imem_req_ready;
        popc = ir_valid && ir_ready;
        last_rv = rv; last_popc = popc; last_irv = ir_valid;
        if (popc && !do_redir && sbq.size() > 0) begin
            chk("ir", ir, sbq[0].data);
            chk("ir_pc", ir_pc, sbq[0].pc);
            popped.push_back(ir_pc);
            void'(sbq.pop_front());
        end
        if (rv) begin
            h = memq.pop_front();
            if (!h.stale && !do_redir) begin
                e.data = mdata(h.addr);
                e.pc   = h.addr;
                sbq.push_back(e);
            end
        end
        if (hs) begin
            chk("req_addr", imem_req_addr, exp_pc);
            reqs.push_back(imem_req_addr);
            h.addr = exp_pc; h.cyc = cyc; h.stale = 1'b0;
            memq.push_back(h);
            exp_pc += 32'd4;
        end
        if (do_redir) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            sbq.delete();
            exp_pc   = redir_pc & ~32'h3;
            do_redir = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit rr, input bit mr);
        for (int i = 0; i < n; i++) begin
            if (rr) rdy = 1'($urandom_range(0, 1));
            if (mr) mem_rdy = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        do_redir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        memq.delete();
        sbq.delete();
        exp_pc = 32'h0;
        rdy = 1'b1;
        mem_rdy = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    row_t rows[4];

    initial begin
        int k, p, n;
        bit found;

        rows[0] = '{lat: 3, pre: 6, post: 25, rr: 0, mr: 0,
                    rd_pc: 32'h0000_0103, exp1: 32'h0000_0100,
                    exp2: 32'h0000_0104};
        rows[1] = '{lat: 1, pre: 5, post: 20, rr: 0, mr: 0,
                    rd_pc: 32'h0000_2002, exp1: 32'h0000_2000,
                    exp2: 32'h0000_2004};
        rows[2] = '{lat: 2, pre: 7, post: 20, rr: 0, mr: 0,
                    rd_pc: 32'hFFFF_FFFF, exp1: 32'hFFFF_FFFC,
                    exp2: 32'h0000_0000};
        rows[3] = '{lat: 2, pre: 9, post: 60, rr: 1, mr: 1,
                    rd_pc: 32'h0000_0441, exp1: 32'h0000_0440,
                    exp2: 32'h0000_0444};

        // steady stream, 1-cycle memory
        do_reset();
        lat = 1;
        k = reqs.size(); p = popped.size();
        run(20, 0, 0);
        chk_q("stream_req0", reqs, k, 32'h0);
        chk_q("stream_req1", reqs, k + 1, 32'h4);
        chk_q("stream_pc0", popped, p, 32'h0);
        chk_q("stream_pc1", popped, p + 1, 32'h4);
        chk_q("stream_pc2", popped, p + 2, 32'h8);
        chk_q("stream_pc3", popped, p + 3, 32'hC);
        chk("stream_count", 32'(popped.size() - p >= 10), 32'h1);

        // decode stall: credit limit, buffer holds 0x0 and 0x4
        do_reset();
        lat = 1; rdy = 1'b0;
        k = reqs.size(); p = popped.size();
        run(10, 0, 0);
        chk("stall_reqs", 32'(reqs.size() - k), 32'(D));
        chk("stall_ir_valid", 32'(ir_valid), 32'h1);
        chk("stall_ir_pc", ir_pc, 32'h0);
        rdy = 1'b1;
        run(12, 0, 0);
        chk_q("resume_pc0", popped, p, 32'h0);
        chk_q("resume_pc1", popped, p + 1, 32'h4);
        chk_q("resume_pc2", popped, p + 2, 32'h8);

        // redirect scenarios
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lat = rows[r].lat;
            run(rows[r].pre, rows[r].rr, rows[r].mr);
            k = reqs.size(); p = popped.size();
            do_redir = 1'b1;
            redir_pc = rows[r].rd_pc;
            step();
            run(rows[r].post, rows[r].rr, rows[r].mr);
            rdy = 1'b1; mem_rdy = 1'b1;
            run(10, 0, 0);
            chk_q($sformatf("redir%0d_req", r), reqs, k, rows[r].exp1);
            chk_q($sformatf("redir%0d_pc0", r), popped, p, rows[r].exp1);
            chk_q($sformatf("redir%0d_pc1", r), popped, p + 1, rows[r].exp2);
        end

        // redirect coincident with a response and a decode pop
        do_reset();
        lat = 1;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            found = (memq.size() > 0) && (memq[0].cyc + lat <= cyc + 1)
                 && (sbq.size() > 0);
            if (!found) step();
            n++;
        end
        chk("coinc_setup", 32'(found), 32'h1);
        k = reqs.size(); p = popped.size();
        do_redir = 1'b1;
        redir_pc = 32'h0000_0802;
        step();
        chk("coinc_rsp", 32'(last_rv), 32'h1);
        chk("coinc_pop", 32'(last_popc), 32'h1);
        step();
        chk("coinc_flush", 32'(last_irv), 32'h0);
        run(12, 0, 0);
        chk_q("coinc_req", reqs, k, 32'h800);
        chk_q("coinc_pc0", popped, p, 32'h800);

        // asynchronous reset in the middle of a cycle
        run(5, 0, 0);
        chk("mid_pre_ir_valid", 32'(last_irv), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req_valid", 32'(imem_req_valid), 32'h0);
        chk("mid_ir_valid", 32'(ir_valid), 32'h0);
        chk("mid_ir", ir, 32'h0);
        chk("mid_ir_pc", ir_pc, 32'h0);
        do_reset();
        k = reqs.size(); p = popped.size();
        run(8, 0, 0);
        chk_q("mid_after_req", reqs, k, 32'h0);
        chk_q("mid_after_pc", popped, p, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage directly upstream of the decode/control stage.
- Holds the program counter and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs in a small FIFO and presents them to decode as ir/ir_pc with a valid/ready handshake.
- Takes branch/jump redirects from execute, flushes the FIFO and discards stale in-flight responses.

Parameters:
- IR_WIDTH, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, PC after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  IR_WIDTH  word-aligned fetch address (= pc).
- imem_rsp_valid  input  1  response valid; in order, ≥1 cycle after request; no backpressure.
- imem_rsp_data  input  IR_WIDTH  fetched instruction word.
- redirect_valid  input  1  branch taken / jump from execute.
- redirect_pc  input  IR_WIDTH  redirect target; bits[1:0] ignored (forced 00).
- ir_valid  output  1  ir/ir_pc hold a valid instruction.
- ir_ready  input  1  decode consumes ir this cycle.
- ir  output  IR_WIDTH  instruction to decode (FIFO head).
- ir_pc  output  IR_WIDTH  address of ir.

Behaviour:
- Reset is asynchronous and active-low.
  - pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, storage zeroed.
  - Outputs under reset: imem_req_valid=0, ir_valid=0, ir=0, ir_pc=0.
  - The memory shares rst_n; no pre-reset response may arrive after release.
- Request issue:
  - imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). Combinational from state and redirect_valid only, never from imem_req_ready.
  - First request goes out in the first cycle after reset release, addr RESET_PC.
  - On handshake (valid && ready): pc += 4 (wraps mod 2^IR_WIDTH), outstanding += 1.
  - Valid may drop without handshake only because of redirect or credit change.
- Response accept:
  - Every imem_rsp_valid decrements outstanding. The credit rule guarantees the FIFO never overflows.
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise {imem_rsp_data, rsp_pc} is pushed and rsp_pc += 4.
  - A pushed word is visible on ir/ir_valid the next cycle (1-cycle response-to-decode latency).
- Decode handshake:
  - ir_valid = FIFO non-empty; ir/ir_pc = head entry.
  - Pop on ir_valid && ir_ready.
  - Push and pop in the same cycle is legal at any occupancy, count unchanged.
- Redirect (highest priority, single cycle):
  - Next cycle: pc = rsp_pc = {redirect_pc[IR_WIDTH-1:2],2'b00}; FIFO flushed, so ir_valid=0 next cycle.
  - A same-cycle pop is ignored as a flush.
  - drop_cnt = outstanding after this cycle's response and request accounting; no request is issued in this cycle.
  - A response arriving in the redirect cycle is dropped, never pushed.
  - A redirect while drop_cnt > 0 sets drop_cnt to the new total outstanding (old drops included).
  - Back-to-back redirects: the last one wins.
- Counters: outstanding and drop_cnt are clog2(FIFO_DEPTH)+1 bits wide. Any of the following is an assertion failure in simulation:
  - outstanding underflow (a response with outstanding=0);
  - drop_cnt > outstanding;
  - fifo_count > FIFO_DEPTH.
- No combinational path from imem_rsp_* to ir/ir_valid. Paths from redirect_valid to imem_req_valid, and from ir_ready to pop logic, are the only input-to-output-side combinational dependencies.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr as data, ir_ready=1 -> requests at 0x0,0x4,0x8…; ir/ir_pc pairs (0x0,0x0),(0x4,0x4)… one per cycle after fill; no gaps, no duplicates.
- ir_ready=0 for 10 cycles -> at most FIFO_DEPTH requests issued; FIFO holds 0x0,0x4; imem_req_valid=0 with fifo_count+outstanding=2; on ir_ready=1 the stream resumes at 0x8 with nothing lost.
- Memory latency 3, two requests (0x10,0x14) outstanding, redirect_pc=0x103 -> both responses dropped; next request addr 0x100; first ir_pc=0x100.
- Redirect coincident with a response and with ir_valid&&ir_ready -> the response is not pushed, ir_valid=0 next cycle, and the next ir_pc equals the redirect target.
- pc=0xFFFF_FFFC fetch -> next request addr 0x0000_0000 (wrap); ir_pc values 0xFFFF_FFFC then 0x0.
- rst_n asserted mid-stream (asynchronously, mid-cycle) -> outputs clear immediately; after release the first request addr is RESET_PC and the first ir_pc is RESET_PC.
